// File: rtl/sync_fifo_15x8.sv
// sync_fifo_15x8: 15-entry show-ahead synchronous FIFO with sticky overflow/underflow flags
module sync_fifo_15x8 #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_request,
   input  logic                  rd_request,
   input  logic                  clear_overflow_request,
   input  logic                  clear_underflow_request,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow,
   output logic [ADDR_WIDTH-1:0] count,
   output logic [ADDR_WIDTH-1:0] wr_index,
   output logic [ADDR_WIDTH-1:0] rd_index
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
   logic ovf_q, ovf_d, unf_q, unf_d, push, pop;
   always_comb begin
      push  = wr_request && !full;
      pop   = rd_request && !empty;
      wr_d  = push ? ADDR_WIDTH'(wr_q + 1'b1) : wr_q;
      rd_d  = pop ? ADDR_WIDTH'(rd_q + 1'b1) : rd_q;
      ovf_d = (wr_request && full) ? 1'b1 : clear_overflow_request ? 1'b0 : ovf_q;
      unf_d = (rd_request && empty) ? 1'b1 : clear_underflow_request ? 1'b0 : unf_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end
   // Storage is not reset; the empty gate on rd_data hides stale entries.
   always_ff @(posedge clk) begin
      if (!reset && push) mem_q[wr_q] <= wr_data;
   end
   assign count     = ADDR_WIDTH'(wr_q - rd_q);
   assign empty     = wr_q == rd_q;
   assign full      = ADDR_WIDTH'(wr_q + 1'b1) == rd_q;
   assign rd_data   = empty ? '0 : mem_q[rd_q];
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign wr_index  = wr_q;
   assign rd_index  = rd_q;
endmodule

// File: tb/tb_sync_fifo_15x8.sv
// tb_sync_fifo_15x8: directed self-checking bench for sync_fifo_15x8
module tb_sync_fifo_15x8;
   logic clk = 1'b0, reset = 1'b0;
   logic [7:0] wr_data = '0;
   logic wr_request = 1'b0, rd_request = 1'b0;
   logic clear_overflow_request = 1'b0, clear_underflow_request = 1'b0;
   logic [7:0] rd_data;
   logic empty, full, overflow, underflow;
   logic [3:0] count, wr_index, rd_index;
   int n_asrt = 0, n_fail = 0;
   logic [7:0] q[$];

   sync_fifo_15x8 dut (
      .clk(clk), .reset(reset), .wr_data(wr_data), .wr_request(wr_request),
      .rd_request(rd_request), .clear_overflow_request(clear_overflow_request),
      .clear_underflow_request(clear_underflow_request), .rd_data(rd_data),
      .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
      .count(count), .wr_index(wr_index), .rd_index(rd_index)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given strobes; the queue tracks accepted data using pre-edge occupancy.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic co = 1'b0, input logic cu = 1'b0, input logic rs = 1'b0);
      int n;
      n = q.size();
      wr_request = w; wr_data = d; rd_request = r;
      clear_overflow_request = co; clear_underflow_request = cu; reset = rs;
      @(posedge clk);
      #1;
      if (rs) q.delete();
      else begin
         if (r && n > 0) void'(q.pop_front());
         if (w && n < 15) q.push_back(d);
      end
      wr_request = 1'b0; rd_request = 1'b0; reset = 1'b0;
      clear_overflow_request = 1'b0; clear_underflow_request = 1'b0;
   endtask

   initial begin
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      chk("rst_wr_idx", wr_index, 0);
      chk("rst_rd_idx", rd_index, 0);
      // pop on empty
      cyc(0, 0, 1);
      chk("unf_set", underflow, 1);
      chk("unf_rd_idx", rd_index, 0);
      chk("unf_empty", empty, 1);
      cyc(0, 0, 0, 0, 1);
      chk("unf_clear", underflow, 0);
      // three pushes
      cyc(1, 8'h11, 0);
      cyc(1, 8'h22, 0);
      cyc(1, 8'h33, 0);
      chk("p3_count", count, 3);
      chk("p3_empty", empty, 0);
      chk("p3_rd_data", rd_data, 8'h11);
      chk("p3_wr_idx", wr_index, 3);
      chk("p3_rd_idx", rd_index, 0);
      // fill to full, overflow, clear races
      cyc(0, 0, 0, 0, 0, 1);
      chk("rst2_count", count, 0);
      for (int i = 1; i <= 15; i++) cyc(1, 8'(i), 0);
      chk("fill_full", full, 1);
      chk("fill_count", count, 15);
      chk("fill_wr_idx", wr_index, 15);
      cyc(1, 8'hAA, 0);
      chk("ovf_set", overflow, 1);
      chk("ovf_wr_idx", wr_index, 15);
      chk("ovf_count", count, 15);
      cyc(1, 8'hAB, 0, 1, 0);
      chk("ovf_set_wins", overflow, 1);
      cyc(0, 0, 0, 1, 0);
      chk("ovf_clear", overflow, 0);
      for (int i = 1; i <= 15; i++) begin
         chk("drain_data", rd_data, 8'(i));
         cyc(0, 0, 1);
      end
      chk("drain_empty", empty, 1);
      chk("drain_rd_data", rd_data, 0);
      chk("drain_rd_idx", rd_index, 15);
      // push+pop while empty, pointers at 15
      cyc(1, 8'h5A, 1);
      chk("pe_unf", underflow, 1);
      chk("pe_count", count, 1);
      chk("pe_wr_wrap", wr_index, 0);
      chk("pe_rd_data", rd_data, 8'h5A);
      cyc(0, 0, 0, 0, 1);
      chk("pe_unf_clear", underflow, 0);
      // fill to 14 then streaming push+pop across the wrap
      for (int i = 0; i < 13; i++) cyc(1, 8'(8'h60 + i), 0);
      chk("s_count14", count, 14);
      for (int i = 0; i < 20; i++) begin
         chk("s_head", rd_data, q[0]);
         cyc(1, 8'(8'h80 + i), 1);
         chk("s_count", count, 14);
      end
      chk("s_wr_idx", wr_index, 1);
      chk("s_rd_idx", rd_index, 3);
      chk("s_head_end", rd_data, q[0]);
      // push+pop while full
      cyc(1, 8'hC0, 0);
      chk("pf_full", full, 1);
      cyc(1, 8'hD0, 1);
      chk("pf_ovf", overflow, 1);
      chk("pf_count", count, 14);
      chk("pf_full_n", full, 0);
      chk("pf_head", rd_data, q[0]);
      cyc(0, 0, 0, 1, 0);
      chk("pf_ovf_clear", overflow, 0);
      for (int i = 0; i < 14; i++) begin
         chk("pf_drain", rd_data, q[0]);
         cyc(0, 0, 1);
      end
      chk("pf_empty", empty, 1);
      // reset mid-traffic with both flags set
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1);
      for (int i = 0; i < 15; i++) cyc(1, 8'(8'hE0 + i), 0);
      cyc(1, 8'hEE, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1);
      chk("r9_count", count, 9);
      chk("r9_ovf", overflow, 1);
      chk("r9_unf", underflow, 1);
      cyc(1, 8'h77, 1, 0, 0, 1);
      chk("r9_rst_count", count, 0);
      chk("r9_rst_empty", empty, 1);
      chk("r9_rst_wr", wr_index, 0);
      chk("r9_rst_rd", rd_index, 0);
      chk("r9_rst_ovf", overflow, 0);
      chk("r9_rst_unf", underflow, 0);
      chk("r9_rst_data", rd_data, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
